// File: rtl/pc_next_unit_pkg.sv
// Shared encodings for the next-PC unit: branch opcodes, FSM states, fetch step.
package pc_next_unit_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'b0000,
        BR_JAL  = 4'b0001,
        BR_JALR = 4'b0010,
        BR_BEQ  = 4'b1000,
        BR_BNE  = 4'b1001,
        BR_BLT  = 4'b1100,
        BR_BGE  = 4'b1101,
        BR_BLTU = 4'b1110,
        BR_BGEU = 4'b1111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_next_unit_br_cond.sv
// Branch condition evaluation: combinational, zero latency, no handshake.
// Unlisted opcodes and in_valid=0 both resolve to not-taken.
module pc_next_unit_br_cond
    import pc_next_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            in_valid,
    input  logic [3:0]      br_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        if (in_valid) begin
            case (br_op)
                BR_JAL, BR_JALR: taken = 1'b1;
                BR_BEQ:          taken = (rs1 == rs2);
                BR_BNE:          taken = (rs1 != rs2);
                BR_BLT:          taken = ($signed(rs1) <  $signed(rs2));
                BR_BGE:          taken = ($signed(rs1) >= $signed(rs2));
                BR_BLTU:         taken = (rs1 <  rs2);
                BR_BGEU:         taken = (rs1 >= rs2);
                default:         taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch-PC generator: redirects and pulses appear one clock after the cause.
// pc advances only when fetch asserts pc_ready; redirects override pc regardless.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       br_op,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic             csr_redirect,
    input  logic [XLEN-1:0]  csr_target,
    input  logic             halt,
    input  logic             pc_ready,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             exc_misaligned,
    output logic [XLEN-1:0]  exc_tval,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic               flush_q, flush_d;
    logic               exc_q, exc_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic [CNT_W-1:0]   cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0]   cnt_taken_q, cnt_taken_d;

    logic               taken;
    logic [XLEN-1:0]    jalr_sum;
    logic [XLEN-1:0]    target;
    logic               aligned;

    pc_next_unit_br_cond #(.XLEN(XLEN)) u_br_cond (
        .in_valid (in_valid),
        .br_op    (br_op),
        .rs1      (rs1),
        .rs2      (rs2),
        .taken    (taken)
    );

    assign jalr_sum = rs1 + imm;
    assign target   = (br_op == BR_JALR) ? (jalr_sum & ~XLEN'(1)) : (ex_pc + imm);
    assign aligned  = (target[1:0] == 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        flush_d      = 1'b0;
        exc_d        = 1'b0;
        tval_d       = tval_q;
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d    = ST_HALT;
                    pc_valid_d = 1'b0;
                end else begin
                    // Statistics count the resolved branch even when a CSR redirect wins.
                    if (in_valid && br_op[3]) begin
                        cnt_branch_d = cnt_branch_q + CNT_W'(1);
                        if (taken) cnt_taken_d = cnt_taken_q + CNT_W'(1);
                    end
                    if (csr_redirect) begin
                        pc_d    = csr_target;
                        flush_d = 1'b1;
                    end else if (taken && aligned) begin
                        pc_d    = target;
                        flush_d = 1'b1;
                    end else begin
                        if (taken) begin
                            exc_d  = 1'b1;
                            tval_d = target;
                        end
                        if (pc_ready) pc_d = pc_q + XLEN'(INSN_BYTES);
                    end
                end
            end
            ST_HALT: pc_valid_d = 1'b0;
            default: begin
                state_d    = ST_BOOT;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= XLEN'(RESET_PC);
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            exc_q        <= 1'b0;
            tval_q       <= '0;
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            flush_q      <= flush_d;
            exc_q        <= exc_d;
            tval_q       <= tval_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
        end
    end

    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
    assign flush          = flush_q;
    assign exc_misaligned = exc_q;
    assign exc_tval       = tval_q;
    assign cnt_branch     = cnt_branch_q;
    assign cnt_taken      = cnt_taken_q;

endmodule
